// File: rtl/mbn_router_pkg.sv
// ----------------------------------------------------------------------------
// mbn_router_pkg
// Shared types and helpers for the window router.
//   state_e   : sweep FSM states (idle, depthwise sweep, pointwise sweep)
//   mode_e    : load mode selector (MODE_DW = depthwise, MODE_PW = pointwise)
//   idxWidth  : width of the signed row/column index arithmetic
//   selWidth  : select width for an n-entry dimension (never below 1)
//   cfgLegal  : checks a kernel/stride/padding configuration against limits
// ----------------------------------------------------------------------------
package mbn_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DW_SWEEP = 2'd1,
        ST_PW_SWEEP = 2'd2
    } state_e;

    typedef enum logic {
        MODE_DW = 1'b0,
        MODE_PW = 1'b1
    } mode_e;

    localparam int KSIZE_W  = 3;
    localparam int STRIDE_W = 2;
    localparam int PAD_W    = 3;

    // Three extra bits cover the sign plus the worst-case overshoot of
    // x0 + x*stride + kx beyond the buffer width.
    function automatic int idxWidth(input int bufw);
        return $clog2(bufw) + 3;
    endfunction

    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Odd kernel no larger than kmax, non-zero stride no larger than smax,
    // and left padding no wider than the kernel half-width.
    function automatic logic cfgLegal(input logic [KSIZE_W-1:0]  ksize,
                                      input logic [STRIDE_W-1:0] stride,
                                      input logic [PAD_W-1:0]    pad,
                                      input int                  kmax,
                                      input int                  smax);
        return ksize[0]
            && (int'(ksize) <= kmax)
            && (stride != '0)
            && (int'(stride) <= smax)
            && (pad <= (ksize >> 1));
    endfunction

endpackage

// File: rtl/window_tap_select.sv
// ----------------------------------------------------------------------------
// window_tap_select
// Combinational gather of one POY x POX tile from the buffered row block for
// a single kernel tap.
//   rowBuf_i : ROWS x BUFW x DW buffered pixels
//   ky_i     : kernel row tap
//   kx_i     : kernel column tap
//   stride_i : spatial stride
//   x0_i     : tile start column
//   pad_i    : left padding
//   tile_o   : tile[y][x] = rowBuf[y*stride+ky][x0+x*stride+kx-pad], zero when
//              the row or column falls outside the buffer
// ----------------------------------------------------------------------------
module window_tap_select
    import mbn_router_pkg::*;
#(
    parameter int DW   = 32,
    parameter int POY  = 3,
    parameter int POX  = 16,
    parameter int BUFW = 48,
    parameter int ROWS = 9,
    parameter int KW   = 3,
    parameter int XW   = 6
) (
    input  logic [ROWS-1:0][BUFW-1:0][DW-1:0] rowBuf_i,
    input  logic [KW-1:0]                     ky_i,
    input  logic [KW-1:0]                     kx_i,
    input  logic [STRIDE_W-1:0]               stride_i,
    input  logic [XW-1:0]                     x0_i,
    input  logic [PAD_W-1:0]                  pad_i,
    output logic [POY-1:0][POX-1:0][DW-1:0]   tile_o
);

    localparam int IW  = idxWidth(BUFW);
    localparam int RW  = selWidth(ROWS);
    localparam int CSW = selWidth(BUFW);

    localparam logic signed [IW-1:0] BUFW_S = IW'(BUFW);
    localparam logic signed [IW-1:0] ROWS_S = IW'(ROWS);

    logic signed [IW-1:0] strideS;
    logic signed [IW-1:0] x0S;
    logic signed [IW-1:0] kyS;
    logic signed [IW-1:0] kxS;
    logic signed [IW-1:0] padS;
    logic signed [IW-1:0] rowIdx;
    logic signed [IW-1:0] colIdx;

    assign strideS = IW'(stride_i);
    assign x0S     = IW'(x0_i);
    assign kyS     = IW'(ky_i);
    assign kxS     = IW'(kx_i);
    assign padS    = IW'(pad_i);

    // The column index can go negative through padding, so the bounds test
    // looks at the sign bit before the upper limit; only in-range indices
    // ever reach the buffer select.
    always_comb begin
        tile_o = '0;
        rowIdx = '0;
        colIdx = '0;
        for (int y = 0; y < POY; y++) begin
            for (int x = 0; x < POX; x++) begin
                rowIdx = IW'(y) * strideS + kyS;
                colIdx = x0S + IW'(x) * strideS + kxS - padS;
                if (!colIdx[IW-1] && (colIdx < BUFW_S) && (rowIdx < ROWS_S)) begin
                    tile_o[y][x] = rowBuf_i[rowIdx[RW-1:0]][colIdx[CSW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/window_router.sv
// ----------------------------------------------------------------------------
// window_router
// Captures a block of buffered rows with its configuration, then streams
// either a depthwise kernel sweep (ksize*ksize tiles, ky outer / kx inner) or
// a pointwise column sweep (POX columns) with registered outputs.
//   clk_i / rst_ni             : clock, synchronous active-low reset
//   in_valid_i / in_ready_o    : row-block load handshake (ready only when idle)
//   in_data_i                  : ROWS x BUFW x DW row block
//   cfg_mode_i .. cfg_pad_i    : mode, kernel size, stride, start column, pad
//   flush_i                    : abort the current sweep
//   out_valid_o / out_ready_i  : tile handshake
//   out_dw_o                   : POY x POX depthwise tile
//   out_pw_o                   : POY pointwise column
//   out_ky_o / out_kx_o        : tap index of the current tile
//   out_last_o                 : final beat of the block
//   blk_done_o                 : pulse after the last beat is accepted
//   cfg_err_o                  : pulse after an illegal configuration load
// ----------------------------------------------------------------------------
module window_router
    import mbn_router_pkg::*;
#(
    parameter  int DW   = 32,
    parameter  int POY  = 3,
    parameter  int POX  = 16,
    parameter  int BUFW = 48,
    parameter  int KMAX = 5,
    parameter  int SMAX = 2,
    localparam int ROWS = (POY - 1) * SMAX + KMAX,
    localparam int XW   = selWidth(BUFW),
    localparam int KW   = selWidth(KMAX)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [ROWS-1:0][BUFW-1:0][DW-1:0] in_data_i,
    input  logic                              cfg_mode_i,
    input  logic [KSIZE_W-1:0]                cfg_ksize_i,
    input  logic [STRIDE_W-1:0]               cfg_stride_i,
    input  logic [XW-1:0]                     cfg_x0_i,
    input  logic [PAD_W-1:0]                  cfg_pad_i,
    input  logic                              flush_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [POY-1:0][POX-1:0][DW-1:0]   out_dw_o,
    output logic [POY-1:0][DW-1:0]            out_pw_o,
    output logic [KW-1:0]                     out_ky_o,
    output logic [KW-1:0]                     out_kx_o,
    output logic                              out_last_o,
    output logic                              blk_done_o,
    output logic                              cfg_err_o
);

    localparam int PXW = selWidth(POX);
    localparam int CW  = (PXW > KSIZE_W) ? PXW : KSIZE_W;
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] PX_LAST_C = CW'(POX - 1);

    state_e                            state_q, state_d;
    mode_e                             mode_q;
    logic [KSIZE_W-1:0]                ksize_q;
    logic [STRIDE_W-1:0]               stride_q;
    logic [XW-1:0]                     x0_q;
    logic [PAD_W-1:0]                  pad_q;
    logic [ROWS-1:0][BUFW-1:0][DW-1:0] rowBuf_q;

    logic [CW-1:0] rowCnt_q, rowCnt_d;
    logic [CW-1:0] colCnt_q, colCnt_d;
    logic          outValid_q, outValid_d;
    logic          outLast_q, outLast_d;
    logic          blkDone_q, blkDone_d;
    logic          cfgErr_q, cfgErr_d;

    logic [POY-1:0][POX-1:0][DW-1:0] outDw_q, outDw_d;
    logic [POY-1:0][DW-1:0]          outPw_q, outPw_d;
    logic [KW-1:0]                   outKy_q, outKy_d;
    logic [KW-1:0]                   outKx_q, outKx_d;

    logic                              cfgOk;
    logic                              outFire;
    logic                              loadBuf;
    logic                              updateOut;
    logic [KSIZE_W-1:0]                kLast;
    logic [CW-1:0]                     kLastC;
    logic [CW-1:0]                     rowStep;
    logic [CW-1:0]                     colStep;
    logic                              stepLast;
    mode_e                             srcMode;
    logic [ROWS-1:0][BUFW-1:0][DW-1:0] srcBuf;
    logic [STRIDE_W-1:0]               srcStride;
    logic [XW-1:0]                     srcX0;
    logic [PAD_W-1:0]                  srcPad;
    logic [KW-1:0]                     tapKy;
    logic [KW-1:0]                     tapKx;
    logic [PAD_W-1:0]                  tapPad;
    logic [POY-1:0][POX-1:0][DW-1:0]   tile;

    assign cfgOk   = cfgLegal(cfg_ksize_i, cfg_stride_i, cfg_pad_i, KMAX, SMAX);
    assign outFire = outValid_q && out_ready_i;
    assign kLast   = ksize_q - KSIZE_W'(1);
    assign kLastC  = CW'(kLast);

    // On the load cycle the first tile is gathered straight from the incoming
    // block so that it can be registered alongside the block itself.
    assign srcMode   = loadBuf ? mode_e'(cfg_mode_i) : mode_q;
    assign srcBuf    = loadBuf ? in_data_i : rowBuf_q;
    assign srcStride = loadBuf ? cfg_stride_i : stride_q;
    assign srcX0     = loadBuf ? cfg_x0_i : x0_q;
    assign srcPad    = loadBuf ? cfg_pad_i : pad_q;
    assign tapKy     = (srcMode == MODE_PW) ? '0 : KW'(rowCnt_d);
    assign tapKx     = (srcMode == MODE_PW) ? '0 : KW'(colCnt_d);
    assign tapPad    = (srcMode == MODE_PW) ? '0 : srcPad;

    window_tap_select #(
        .DW   (DW),
        .POY  (POY),
        .POX  (POX),
        .BUFW (BUFW),
        .ROWS (ROWS),
        .KW   (KW),
        .XW   (XW)
    ) u_tap (
        .rowBuf_i (srcBuf),
        .ky_i     (tapKy),
        .kx_i     (tapKx),
        .stride_i (srcStride),
        .x0_i     (srcX0),
        .pad_i    (tapPad),
        .tile_o   (tile)
    );

    // Sweep control: state, beat counters and handshake flags. Flush wins
    // over any load or output handshake in the same cycle.
    always_comb begin
        state_d    = state_q;
        rowCnt_d   = rowCnt_q;
        colCnt_d   = colCnt_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        blkDone_d  = 1'b0;
        cfgErr_d   = 1'b0;
        loadBuf    = 1'b0;
        updateOut  = 1'b0;
        rowStep    = rowCnt_q;
        colStep    = colCnt_q + ONE_C;

        if (state_q != ST_PW_SWEEP && colCnt_q == kLastC) begin
            rowStep = rowCnt_q + ONE_C;
            colStep = '0;
        end
        stepLast = (state_q == ST_PW_SWEEP) ? (colStep == PX_LAST_C)
                                            : (rowStep == kLastC && colStep == kLastC);

        if (!flush_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        if (cfgOk) begin
                            loadBuf    = 1'b1;
                            updateOut  = 1'b1;
                            rowCnt_d   = '0;
                            colCnt_d   = '0;
                            outValid_d = 1'b1;
                            if (mode_e'(cfg_mode_i) == MODE_PW) begin
                                state_d   = ST_PW_SWEEP;
                                outLast_d = (POX == 1);
                            end else begin
                                state_d   = ST_DW_SWEEP;
                                outLast_d = (cfg_ksize_i == KSIZE_W'(1));
                            end
                        end else begin
                            cfgErr_d = 1'b1;
                        end
                    end
                end
                ST_DW_SWEEP, ST_PW_SWEEP: begin
                    if (outFire) begin
                        if (outLast_q) begin
                            state_d    = ST_IDLE;
                            rowCnt_d   = '0;
                            colCnt_d   = '0;
                            outValid_d = 1'b0;
                            outLast_d  = 1'b0;
                            blkDone_d  = 1'b1;
                        end else begin
                            rowCnt_d  = rowStep;
                            colCnt_d  = colStep;
                            outLast_d = stepLast;
                            updateOut = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d    = ST_IDLE;
            rowCnt_d   = '0;
            colCnt_d   = '0;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
        end
    end

    // Output data registers load the tile for the beat about to be presented;
    // the unused mode's data port is driven to zero.
    always_comb begin
        outDw_d = outDw_q;
        outPw_d = outPw_q;
        outKy_d = outKy_q;
        outKx_d = outKx_q;
        if (updateOut) begin
            if (srcMode == MODE_PW) begin
                outDw_d = '0;
                outKy_d = '0;
                outKx_d = '0;
                for (int y = 0; y < POY; y++) begin
                    outPw_d[y] = tile[y][colCnt_d[PXW-1:0]];
                end
            end else begin
                outDw_d = tile;
                outPw_d = '0;
                outKy_d = KW'(rowCnt_d);
                outKx_d = KW'(colCnt_d);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_DW;
            ksize_q    <= '0;
            stride_q   <= '0;
            x0_q       <= '0;
            pad_q      <= '0;
            rowBuf_q   <= '0;
            rowCnt_q   <= '0;
            colCnt_q   <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            blkDone_q  <= 1'b0;
            cfgErr_q   <= 1'b0;
            outDw_q    <= '0;
            outPw_q    <= '0;
            outKy_q    <= '0;
            outKx_q    <= '0;
        end else begin
            state_q    <= state_d;
            rowCnt_q   <= rowCnt_d;
            colCnt_q   <= colCnt_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            blkDone_q  <= blkDone_d;
            cfgErr_q   <= cfgErr_d;
            outDw_q    <= outDw_d;
            outPw_q    <= outPw_d;
            outKy_q    <= outKy_d;
            outKx_q    <= outKx_d;
            if (loadBuf) begin
                mode_q   <= mode_e'(cfg_mode_i);
                ksize_q  <= cfg_ksize_i;
                stride_q <= cfg_stride_i;
                x0_q     <= cfg_x0_i;
                pad_q    <= cfg_pad_i;
                rowBuf_q <= in_data_i;
            end
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = outValid_q;
    assign out_last_o  = outLast_q;
    assign out_dw_o    = outDw_q;
    assign out_pw_o    = outPw_q;
    assign out_ky_o    = outKy_q;
    assign out_kx_o    = outKx_q;
    assign blk_done_o  = blkDone_q;
    assign cfg_err_o   = cfgErr_q;

endmodule

// File: tb/tb_window_router.sv
// ----------------------------------------------------------------------------
// tb_window_router
// Directed bench for window_router: loads a ramp block buf[r][c] = 100*r+c
// under several configurations and compares the streamed tiles against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_window_router;

    localparam int DW   = 32;
    localparam int POY  = 3;
    localparam int POX  = 16;
    localparam int BUFW = 48;
    localparam int KMAX = 5;
    localparam int SMAX = 2;
    localparam int ROWS = (POY - 1) * SMAX + KMAX;
    localparam int XW   = $clog2(BUFW);
    localparam int KW   = $clog2(KMAX);

    typedef logic [POY-1:0][POX-1:0][DW-1:0] tile_t;
    typedef logic [POY-1:0][DW-1:0]          col_t;

    logic                              clk;
    logic                              rstN;
    logic                              inValid;
    logic                              inReady;
    logic [ROWS-1:0][BUFW-1:0][DW-1:0] inData;
    logic                              cfgMode;
    logic [2:0]                        cfgKsize;
    logic [1:0]                        cfgStride;
    logic [XW-1:0]                     cfgX0;
    logic [2:0]                        cfgPad;
    logic                              flush;
    logic                              outValid;
    logic                              outReady;
    tile_t                             outDw;
    col_t                              outPw;
    logic [KW-1:0]                     outKy;
    logic [KW-1:0]                     outKx;
    logic                              outLast;
    logic                              blkDone;
    logic                              cfgErr;

    int nChecks = 0;
    int nFails  = 0;

    tile_t         capDw   [0:63];
    col_t          capPw   [0:63];
    logic [KW-1:0] capKy   [0:63];
    logic [KW-1:0] capKx   [0:63];
    logic          capLast [0:63];

    int beats;
    int dones;

    window_router #(
        .DW   (DW),
        .POY  (POY),
        .POX  (POX),
        .BUFW (BUFW),
        .KMAX (KMAX),
        .SMAX (SMAX)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .in_valid_i   (inValid),
        .in_ready_o   (inReady),
        .in_data_i    (inData),
        .cfg_mode_i   (cfgMode),
        .cfg_ksize_i  (cfgKsize),
        .cfg_stride_i (cfgStride),
        .cfg_x0_i     (cfgX0),
        .cfg_pad_i    (cfgPad),
        .flush_i      (flush),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_dw_o     (outDw),
        .out_pw_o     (outPw),
        .out_ky_o     (outKy),
        .out_kx_o     (outKx),
        .out_last_o   (outLast),
        .blk_done_o   (blkDone),
        .cfg_err_o    (cfgErr)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one row-block load for a single cycle; called on a falling
    // edge and returns on the falling edge after the load edge.
    task automatic applyStimulus(input logic mode, input logic [2:0] k, input logic [1:0] s,
                                 input logic [XW-1:0] x0, input logic [2:0] p);
        cfgMode   = mode;
        cfgKsize  = k;
        cfgStride = s;
        cfgX0     = x0;
        cfgPad    = p;
        inValid   = 1'b1;
        checkOutput("load_ready", 64'(inReady), 64'd1);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Consumes a sweep with out_ready high, capturing each presented beat.
    // stallBeat holds out_ready low for four cycles on that beat; flushBeat
    // raises flush alongside out_ready on that beat. Negative disables.
    task automatic runSweep(input int stallBeat, input int flushBeat,
                            output int nBeats, output int nDone);
        int idle;
        bit finished;
        bit flushed;
        nBeats   = 0;
        nDone    = 0;
        idle     = 0;
        finished = 1'b0;
        outReady = 1'b1;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (blkDone) nDone++;
            if (outValid) begin
                if (nBeats < 64) begin
                    capDw[nBeats]   = outDw;
                    capPw[nBeats]   = outPw;
                    capKy[nBeats]   = outKy;
                    capKx[nBeats]   = outKx;
                    capLast[nBeats] = outLast;
                end
                if (nBeats == stallBeat) begin
                    outReady = 1'b0;
                    for (int h = 0; h < 4; h++) begin
                        @(negedge clk);
                        checkOutput("hold_valid", 64'(outValid), 64'd1);
                        checkOutput("hold_dw", 64'(outDw == capDw[nBeats]), 64'd1);
                        checkOutput("hold_ky", 64'(outKy), 64'(capKy[nBeats]));
                        checkOutput("hold_kx", 64'(outKx), 64'(capKx[nBeats]));
                    end
                    outReady = 1'b1;
                end
                flushed = (nBeats == flushBeat);
                if (flushed) flush = 1'b1;
                nBeats++;
                @(negedge clk);
                if (flushed) begin
                    flush = 1'b0;
                    checkOutput("flush_valid", 64'(outValid), 64'd0);
                    checkOutput("flush_ready", 64'(inReady), 64'd1);
                end
            end else begin
                if (nBeats > 0) idle++;
                if (idle >= 3) finished = 1'b1;
                else @(negedge clk);
            end
        end
        checkOutput("sweep_end", 64'(finished), 64'd1);
    endtask

    // Loads an illegal configuration and expects a single cfg_err pulse.
    task automatic checkCfgErr(input string tag, input logic [2:0] k, input logic [1:0] s,
                               input logic [2:0] p);
        applyStimulus(1'b0, k, s, XW'(8), p);
        checkOutput({tag, "_err"}, 64'(cfgErr), 64'd1);
        checkOutput({tag, "_valid"}, 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_err_clr"}, 64'(cfgErr), 64'd0);
        checkOutput({tag, "_valid2"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_ready"}, 64'(inReady), 64'd1);
    endtask

    initial begin
        rstN      = 1'b0;
        inValid   = 1'b0;
        cfgMode   = 1'b0;
        cfgKsize  = '0;
        cfgStride = '0;
        cfgX0     = '0;
        cfgPad    = '0;
        flush     = 1'b0;
        outReady  = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < BUFW; c++) begin
                inData[r][c] = DW'(100 * r + c);
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_out_last", 64'(outLast), 64'd0);
        checkOutput("rst_blk_done", 64'(blkDone), 64'd0);
        checkOutput("rst_cfg_err", 64'(cfgErr), 64'd0);
        checkOutput("rst_ky", 64'(outKy), 64'd0);
        checkOutput("rst_kx", 64'(outKx), 64'd0);
        checkOutput("rst_dw_zero", 64'(outDw == '0), 64'd1);
        checkOutput("rst_pw_zero", 64'(outPw == '0), 64'd1);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);

        // Depthwise 3x3, stride 1, x0 0, pad 1
        applyStimulus(1'b0, 3'd3, 2'd1, XW'(0), 3'd1);
        runSweep(-1, -1, beats, dones);
        checkOutput("k3_beats", 64'(beats), 64'd9);
        checkOutput("k3_done", 64'(dones), 64'd1);
        checkOutput("k3_b0_dw00", 64'(capDw[0][0][0]), 64'd0);
        checkOutput("k3_b0_dw01", 64'(capDw[0][0][1]), 64'd0);
        checkOutput("k3_b0_dw11", 64'(capDw[0][1][1]), 64'd100);
        checkOutput("k3_b2_kx", 64'(capKx[2]), 64'd2);
        checkOutput("k3_b3_ky", 64'(capKy[3]), 64'd1);
        checkOutput("k3_b3_kx", 64'(capKx[3]), 64'd0);
        checkOutput("k3_b4_ky", 64'(capKy[4]), 64'd1);
        checkOutput("k3_b4_kx", 64'(capKx[4]), 64'd1);
        checkOutput("k3_b4_dw25", 64'(capDw[4][2][5]), 64'd305);
        checkOutput("k3_b8_dw10", 64'(capDw[8][1][0]), 64'd301);
        checkOutput("k3_b8_ky", 64'(capKy[8]), 64'd2);
        checkOutput("k3_b7_last", 64'(capLast[7]), 64'd0);
        checkOutput("k3_b8_last", 64'(capLast[8]), 64'd1);

        // Depthwise 5x5, stride 2, x0 8, pad 0
        applyStimulus(1'b0, 3'd5, 2'd2, XW'(8), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("k5_beats", 64'(beats), 64'd25);
        checkOutput("k5_done", 64'(dones), 64'd1);
        checkOutput("k5_b0_dw00", 64'(capDw[0][0][0]), 64'd8);
        checkOutput("k5_b12_dw13", 64'(capDw[12][1][3]), 64'd416);
        checkOutput("k5_b24_dw215", 64'(capDw[24][2][15]), 64'd842);
        checkOutput("k5_b24_ky", 64'(capKy[24]), 64'd4);
        checkOutput("k5_b24_last", 64'(capLast[24]), 64'd1);
        checkOutput("k5_b23_last", 64'(capLast[23]), 64'd0);

        // Depthwise 5x5, stride 2, x0 14: right edge runs past the buffer
        applyStimulus(1'b0, 3'd5, 2'd2, XW'(14), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("edge_beats", 64'(beats), 64'd25);
        checkOutput("edge_b4_dw015", 64'(capDw[4][0][15]), 64'd0);
        checkOutput("edge_b4_dw014", 64'(capDw[4][0][14]), 64'd46);
        checkOutput("edge_b4_dw214", 64'(capDw[4][2][14]), 64'd446);

        // Pointwise, stride 1, x0 32 (kernel size field ignored)
        applyStimulus(1'b1, 3'd3, 2'd1, XW'(32), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("pw1_beats", 64'(beats), 64'd16);
        checkOutput("pw1_done", 64'(dones), 64'd1);
        checkOutput("pw1_b0_pw0", 64'(capPw[0][0]), 64'd32);
        checkOutput("pw1_b0_pw2", 64'(capPw[0][2]), 64'd232);
        checkOutput("pw1_b15_pw1", 64'(capPw[15][1]), 64'd147);
        checkOutput("pw1_b5_kx", 64'(capKx[5]), 64'd0);
        checkOutput("pw1_b15_ky", 64'(capKy[15]), 64'd0);
        checkOutput("pw1_b15_kx", 64'(capKx[15]), 64'd0);
        checkOutput("pw1_b14_last", 64'(capLast[14]), 64'd0);
        checkOutput("pw1_b15_last", 64'(capLast[15]), 64'd1);

        // Pointwise, stride 2, x0 32: upper columns fall off the buffer
        applyStimulus(1'b1, 3'd1, 2'd2, XW'(32), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("pw2_beats", 64'(beats), 64'd16);
        checkOutput("pw2_b7_pw2", 64'(capPw[7][2]), 64'd446);
        checkOutput("pw2_b8_pw0", 64'(capPw[8][0]), 64'd0);

        // Back-pressure on the third beat
        applyStimulus(1'b0, 3'd3, 2'd1, XW'(0), 3'd1);
        runSweep(2, -1, beats, dones);
        checkOutput("stall_beats", 64'(beats), 64'd9);
        checkOutput("stall_done", 64'(dones), 64'd1);
        checkOutput("stall_b2_kx", 64'(capKx[2]), 64'd2);
        checkOutput("stall_b3_ky", 64'(capKy[3]), 64'd1);

        // Illegal configurations, then a legal 1x1 load
        checkCfgErr("cfg_k4", 3'd4, 2'd1, 3'd0);
        checkCfgErr("cfg_k7", 3'd7, 2'd1, 3'd0);
        checkCfgErr("cfg_s0", 3'd3, 2'd0, 3'd0);
        checkCfgErr("cfg_s3", 3'd3, 2'd3, 3'd0);
        checkCfgErr("cfg_pad", 3'd3, 2'd1, 3'd2);
        applyStimulus(1'b0, 3'd1, 2'd1, XW'(5), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("k1_beats", 64'(beats), 64'd1);
        checkOutput("k1_done", 64'(dones), 64'd1);
        checkOutput("k1_dw12", 64'(capDw[0][1][2]), 64'd107);
        checkOutput("k1_last", 64'(capLast[0]), 64'd1);

        // Flush on the fifth beat together with out_ready
        applyStimulus(1'b0, 3'd3, 2'd1, XW'(0), 3'd1);
        runSweep(-1, 4, beats, dones);
        checkOutput("flush_beats", 64'(beats), 64'd5);
        checkOutput("flush_done", 64'(dones), 64'd0);
        applyStimulus(1'b0, 3'd1, 2'd1, XW'(5), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("flush_next_beats", 64'(beats), 64'd1);

        // Reset in the middle of a sweep
        applyStimulus(1'b0, 3'd3, 2'd1, XW'(0), 3'd1);
        outReady = 1'b1;
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
        checkOutput("mid_rst_ky", 64'(outKy), 64'd0);
        checkOutput("mid_rst_dw_zero", 64'(outDw == '0), 64'd1);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", 64'(inReady), 64'd1);
        checkOutput("mid_rst_done", 64'(blkDone), 64'd0);
        applyStimulus(1'b0, 3'd1, 2'd1, XW'(5), 3'd0);
        runSweep(-1, -1, beats, dones);
        checkOutput("mid_rst_next_beats", 64'(beats), 64'd1);
        checkOutput("mid_rst_next_dw", 64'(capDw[0][1][2]), 64'd107);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/window_router.md
WINDOW_ROUTER -- requirements
Module: window_router

Interface
REQ-001 Param DW, default 32: pixel width in bits.
REQ-002 Param POY, default 3: output rows per tile.
REQ-003 Param POX, default 16: output columns per tile.
REQ-004 Param BUFW, default 48: buffered columns per row.
REQ-005 Param KMAX, default 5: largest kernel size (odd); SMAX, default 2: largest stride; ROWS = (POY-1)*SMAX+KMAX, derived.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 in_valid / in_ready  in / out  1  row-block load handshake.
REQ-009 in_data  in  ROWS x BUFW x DW  row block, captured on handshake.
REQ-010 cfg_mode  in  1  0 = depthwise sweep, 1 = pointwise; sampled with in_data.
REQ-011 cfg_ksize  in  3  kernel size; cfg_stride  in  2  stride; cfg_x0  in  clog2(BUFW)  tile start column; cfg_pad  in  3  left padding; all sampled with in_data.
REQ-012 flush  in  1  abort current sweep.
REQ-013 out_valid / out_ready  out / in  1  tile handshake.
REQ-014 out_dw  out  POY x POX x DW  depthwise tile.
REQ-015 out_pw  out  POY x DW  pointwise column.
REQ-016 out_ky, out_kx  out  clog2(KMAX) each  tap index of current tile; out_last  out  1  final beat of block.
REQ-017 blk_done  out  1  one-cycle pulse after last beat accepted; cfg_err  out  1  one-cycle illegal-config pulse.

Function
REQ-018 FSM states IDLE, DW_SWEEP, PW_SWEEP; in_ready = 1 only in IDLE.
REQ-019 In IDLE, in_valid=1 with legal config: capture in_data and config; next state DW_SWEEP (mode 0) or PW_SWEEP (mode 1).
REQ-020 Legal config: ksize odd, 1..KMAX; stride 1..SMAX; pad <= ksize/2. Otherwise: input consumed, cfg_err pulses the next cycle, FSM stays IDLE, no output.
REQ-021 DW_SWEEP emits ksize*ksize beats, ky outer and kx inner, 0..ksize-1 each.
REQ-022 Per DW beat: out_dw[y][x] = buf[y*stride+ky][c], where c = x0 + x*stride + kx - pad, computed signed; zero when c<0, c>=BUFW, or row index >= ROWS.
REQ-023 PW_SWEEP ignores ksize and emits POX beats, x = 0..POX-1: out_pw[y] = buf[y*stride][x0+x*stride], zero when out of range; out_ky = out_kx = 0.
REQ-024 Outputs are registered: first out_valid appears the cycle after the load handshake; one beat per cycle under out_ready=1.
REQ-025 out_valid=1 and out_ready=0: all outputs and counters hold.
REQ-026 out_last = 1 on the final beat only; on its handshake, FSM goes to IDLE and blk_done pulses the next cycle.
REQ-027 Next load may be accepted the cycle after the last beat handshake; no overlap with a sweep.
REQ-028 flush=1 in any state: out_valid=0 the next cycle, counters cleared, FSM IDLE, no blk_done; flush overrides a simultaneous load or output handshake.
REQ-029 Out-of-range data is never read; index arithmetic width is clog2(BUFW)+3 bits, signed.

Reset
REQ-030 rst_n=0 at a rising edge: FSM IDLE, out_valid/out_last/blk_done/cfg_err = 0, out_ky/out_kx = 0, data outputs zero, config registers zero.
REQ-031 Reset mid-sweep discards the sweep; in_ready=1 on the first cycle after release.

Structure
REQ-032 Package mbn_router_pkg holds the state enum, the mode enum (MODE_DW, MODE_PW), and index-width constants/functions shared with the addressing logic.
REQ-033 One sub-module, window_tap_select: combinational gather of one POY x POX tile for (ky, kx, stride, x0, pad), including zero-padding. PW reuses it with ky = kx = 0 and POX lanes.

Verification
REQ-034 Load ramp buf[r][c] = 100*r+c, ksize 3, stride 1, x0 0, pad 1: 9 beats; beat (0,0) out_dw[0][0] = 0 (pad), out_dw[0][1] = 0; beat (1,1) out_dw[2][5] = 305; out_last on beat 9; blk_done follows.
REQ-035 ksize 5, stride 2, x0 8, pad 0: beat (4,4) out_dw[2][15] = 100*8+42 = 842; beat with c = 48 yields 0.
REQ-036 PW mode, stride 1, x0 32: 16 beats; beat 15 out_pw[1] = 147; out_ky = out_kx = 0.
REQ-037 Hold out_ready=0 for 4 cycles on beat 3: out_dw, out_ky and out_kx stable; total beats still 9.
REQ-038 ksize 4: cfg_err pulses once, out_valid stays 0, next legal load accepted.
REQ-039 flush asserted on beat 5 together with out_ready=1: no further beats, no blk_done, in_ready=1 the next cycle.
